imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the processor's byte-wide instruction memory. Accepts a framed
//  program image over a valid/ready byte stream, writes the payload into instruction
//  memory starting at BASE_ADDR, and verifies an XOR checksum. It then releases the
//  core (cpu_hold low) so fetch begins reading the loaded program at PC=0.
// PARAMETERS
//  ADDR_W     11     instruction memory address width (2048 bytes)
//  MAGIC      8'hA5  frame start byte
//  BASE_ADDR  0      first memory address written (ADDR_W bits)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_data    in   8       stream byte
//  in_valid   in   1       in_data valid
//  in_ready   out  1       loader accepts byte; transfer = in_valid & in_ready
//  clear      in   1       leave DONE/ERR, return to IDLE (ignored in other states)
//  mem_we     out  1       instruction memory write strobe, one cycle per byte
//  mem_addr   out  ADDR_W  write address
//  mem_wdata  out  8       write data
//  cpu_hold   out  1       1 = processor held (PC frozen at 0); 0 = run
//  load_done  out  1       image loaded and checksum good (level)
//  load_err   out  1       load failed (level)
//  err_code   out  2       0 none, 1 length overflow, 2 checksum mismatch
//  byte_cnt   out  ADDR_W+1  payload bytes accepted so far in current frame
// BEHAVIOUR
//  Frame: MAGIC, LEN[7:0], LEN[15:8], LEN payload bytes, CSUM = XOR of payload.
//  Reset (async, rst_n=0): state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0,
//   cpu_hold=1, load_done=0, load_err=0, err_code=0, byte_cnt=0, length/xor regs 0.
//   in_ready rises the first clk edge after reset release.
//  FSM: IDLE -> LEN_LO -> LEN_HI -> DATA -> CSUM -> DONE | ERR; advance only on transfer.
//   IDLE: byte==MAGIC -> LEN_LO; any other byte consumed and dropped, stay IDLE.
//   LEN_HI: length captured; LEN > 2^ADDR_W -> ERR code 1; LEN==0 -> CSUM; else DATA.
//   DATA: each transfer: xor ^= byte, byte_cnt++; after LEN-th byte -> CSUM.
//   CSUM: byte==xor -> DONE else ERR code 2.
//   DONE: load_done=1, cpu_hold=0, in_ready=0. ERR: load_err=1, cpu_hold=1, in_ready=0.
//   DONE/ERR + clear -> IDLE: load_done, load_err, err_code, byte_cnt, xor cleared,
//    cpu_hold=1 (core re-held before the next image).
//  in_ready=1 in IDLE..CSUM, 0 in DONE/ERR; combinationally independent of in_valid.
//  Memory write latency 1: DATA transfer at edge k -> mem_we=1 during cycle k+1 with
//   mem_addr=(BASE_ADDR+idx) mod 2^ADDR_W (idx=0..LEN-1), mem_wdata=byte. mem_we is
//   single-cycle; back-to-back transfers give back-to-back writes, no stalls.
//  Address wrap: BASE_ADDR+idx wraps modulo 2^ADDR_W; LEN==2^ADDR_W writes every
//   location exactly once.
//  cpu_hold falls on the same edge DONE is entered (after last mem_we has issued).
//  Writes already made are never undone (ERR or reset mid-frame leaves partial image).
//  Reset mid-frame: immediate return to IDLE, no further mem_we; next frame restarts.
//  in_valid low mid-frame: state held indefinitely; no timeout.
// TESTING
//  1) Frame A5 03 00 30 F0 04 C4 -> mem_we x3: addr0=30,1=F0,2=04; DONE,
//     load_done=1, cpu_hold=0, byte_cnt=3.
//  2) Frame A5 02 00 60 03 00 (bad csum, expect 63) -> 2 writes, ERR, err_code=2,
//     cpu_hold=1; clear -> IDLE, in_ready=1, err_code=0.
//  3) Bytes 00 FF A5 01 00 10 10 -> first two dropped, one write addr0=10, DONE.
//  4) A5 01 08 (LEN=2049, ADDR_W=11) -> ERR code 1 right after LEN_HI, no mem_we.
//  5) A5 00 00 00 -> zero writes, DONE; BASE_ADDR=2046, LEN=4 -> addrs 2046,2047,0,1.
//  6) rst_n low after 2 of 5 payload bytes -> all outputs at reset values
//     asynchronously; new full frame then loads and reaches DONE.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: framed byte stream -> imem writes.
// Releases the core only after a good checksum.
module imem_loader #(
    parameter int                ADDR_W    = 11,
    parameter logic [7:0]        MAGIC     = 8'hA5,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  xsum;

    logic            xfer;
    logic [16:0]     len_full;
    logic [ADDR_W:0] cnt_nxt;
    logic            last;

    // Handshake and derived values for the current byte
    always_comb begin
        xfer     = in_valid & in_ready;
        len_full = {1'b0, in_data, len_lo};
        cnt_nxt  = byte_cnt + 1'b1;
        last     = (17'(cnt_nxt) == {1'b0, len});
    end

    // Frame parser FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= 2'd0;
            byte_cnt  <= '0;
            len_lo    <= '0;
            len       <= '0;
            xsum      <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer && in_data == MAGIC) begin
                        state    <= S_LEN_LO;
                        byte_cnt <= '0;
                        xsum     <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= in_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len <= len_full[15:0];
                        if (len_full > MAX_LEN) begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                            err_code <= 2'd1;
                            in_ready <= 1'b0;
                        end else if (len_full == 17'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        xsum      <= xsum ^ in_data;
                        byte_cnt  <= cnt_nxt;
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_ADDR + byte_cnt[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        if (last) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == xsum) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                            err_code <= 2'd2;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (clear) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        err_code  <= 2'd0;
                        byte_cnt  <= '0;
                        xsum      <= '0;
                        cpu_hold  <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame vectors, overflow, wrap,
// full-depth load and asynchronous reset mid-frame.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  d1 = '0, d2 = '0;
    logic        v1 = 1'b0, v2 = 1'b0;
    logic        c1 = 1'b0, c2 = 1'b0;
    logic        rdy1, rdy2, we1, we2;
    logic [10:0] a1, a2;
    logic [7:0]  wd1, wd2;
    logic        h1, h2, dn1, dn2, er1, er2;
    logic [1:0]  ec1, ec2;
    logic [11:0] bc1, bc2;

    int checks = 0;
    int failures = 0;

    logic [18:0] wq1[$];
    logic [18:0] wq2[$];

    always #5 clk = ~clk;

    imem_loader u1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d1), .in_valid(v1), .in_ready(rdy1),
        .clear(c1),
        .mem_we(we1), .mem_addr(a1), .mem_wdata(wd1),
        .cpu_hold(h1), .load_done(dn1), .load_err(er1),
        .err_code(ec1), .byte_cnt(bc1)
    );

    imem_loader #(.BASE_ADDR(11'd2046)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d2), .in_valid(v2), .in_ready(rdy2),
        .clear(c2),
        .mem_we(we2), .mem_addr(a2), .mem_wdata(wd2),
        .cpu_hold(h2), .load_done(dn2), .load_err(er2),
        .err_code(ec2), .byte_cnt(bc2)
    );

    // Write monitors
    always @(posedge clk) begin
        if (we1) wq1.push_back({a1, wd1});
        if (we2) wq2.push_back({a2, wd2});
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input int u, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (((u == 1) ? rdy1 : rdy2) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout u%0d act=0 exp=1", u);
        end else begin
            if (u == 1) begin d1 = b; v1 = 1'b1; end
            else begin d2 = b; v2 = 1'b1; end
            @(posedge clk);
            #1;
            v1 = 1'b0;
            v2 = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        c1 = 1'b1;
        @(negedge clk);
        c1 = 1'b0;
        #1;
        chk("clr ready", 32'(rdy1), 32'd1);
        chk("clr hold", 32'(h1), 32'd1);
        chk("clr done", 32'(dn1), 32'd0);
        chk("clr err", 32'(er1), 32'd0);
        chk("clr code", 32'(ec1), 32'd0);
        chk("clr cnt", 32'(bc1), 32'd0);
    endtask

    typedef struct {
        int              n;
        logic [7:0][7:0] b;
        int              nwr;
        logic [2:0][10:0] wa;
        logic [2:0][7:0] wd;
        logic            done;
        logic            err;
        logic [1:0]      code;
        logic [11:0]     cnt;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{n: 7, b: 64'hA5030030F004C400, nwr: 3,
                  wa: {11'd0, 11'd1, 11'd2},
                  wd: {8'h30, 8'hF0, 8'h04},
                  done: 1'b1, err: 1'b0, code: 2'd0, cnt: 12'd3};
        vt[1] = '{n: 6, b: 64'hA502006003000000, nwr: 2,
                  wa: {11'd0, 11'd1, 11'd0},
                  wd: {8'h60, 8'h03, 8'h00},
                  done: 1'b0, err: 1'b1, code: 2'd2, cnt: 12'd2};
        vt[2] = '{n: 7, b: 64'h00FFA50100101000, nwr: 1,
                  wa: {11'd0, 11'd0, 11'd0},
                  wd: {8'h10, 8'h00, 8'h00},
                  done: 1'b1, err: 1'b0, code: 2'd0, cnt: 12'd1};
        vt[3] = '{n: 3, b: 64'hA501080000000000, nwr: 0,
                  wa: '0, wd: '0,
                  done: 1'b0, err: 1'b1, code: 2'd1, cnt: 12'd0};
        vt[4] = '{n: 4, b: 64'hA500000000000000, nwr: 0,
                  wa: '0, wd: '0,
                  done: 1'b1, err: 1'b0, code: 2'd0, cnt: 12'd0};

        // Reset state and first-edge in_ready
        #12;
        chk("rst ready", 32'(rdy1), 32'd0);
        chk("rst hold", 32'(h1), 32'd1);
        chk("rst we", 32'(we1), 32'd0);
        chk("rst cnt", 32'(bc1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel ready pre", 32'(rdy1), 32'd0);
        @(posedge clk);
        #1;
        chk("rel ready post", 32'(rdy1), 32'd1);

        // Table-driven frames on u1
        for (int i = 0; i < 5; i++) begin
            wq1.delete();
            for (int k = 0; k < vt[i].n; k++) send(1, vt[i].b[7-k]);
            @(negedge clk);
            chk($sformatf("v%0d done", i), 32'(dn1), 32'(vt[i].done));
            chk($sformatf("v%0d err", i), 32'(er1), 32'(vt[i].err));
            chk($sformatf("v%0d code", i), 32'(ec1), 32'(vt[i].code));
            chk($sformatf("v%0d hold", i), 32'(h1), 32'(!vt[i].done));
            chk($sformatf("v%0d ready", i), 32'(rdy1), 32'd0);
            chk($sformatf("v%0d cnt", i), 32'(bc1), 32'(vt[i].cnt));
            chk($sformatf("v%0d nwr", i), 32'(wq1.size()), 32'(vt[i].nwr));
            for (int k = 0; k < vt[i].nwr && k < wq1.size(); k++)
                chk($sformatf("v%0d wr%0d", i, k), 32'(wq1[k]),
                    32'({vt[i].wa[2-k], vt[i].wd[2-k]}));
            do_clear();
        end

        // Address wrap on u2 with BASE_ADDR=2046
        send(2, 8'hA5); send(2, 8'h04); send(2, 8'h00);
        send(2, 8'h11); send(2, 8'h22); send(2, 8'h33); send(2, 8'h44);
        send(2, 8'h44);
        @(negedge clk);
        chk("wrap done", 32'(dn2), 32'd1);
        chk("wrap nwr", 32'(wq2.size()), 32'd4);
        if (wq2.size() == 4) begin
            chk("wrap w0", 32'(wq2[0]), 32'({11'd2046, 8'h11}));
            chk("wrap w1", 32'(wq2[1]), 32'({11'd2047, 8'h22}));
            chk("wrap w2", 32'(wq2[2]), 32'({11'd0, 8'h33}));
            chk("wrap w3", 32'(wq2[3]), 32'({11'd1, 8'h44}));
        end

        // in_valid idle mid-frame: state held
        wq1.delete();
        send(1, 8'hA5); send(1, 8'h01); send(1, 8'h00);
        repeat (20) @(negedge clk);
        chk("stall ready", 32'(rdy1), 32'd1);
        chk("stall done", 32'(dn1), 32'd0);
        send(1, 8'h55); send(1, 8'h55);
        @(negedge clk);
        chk("stall done2", 32'(dn1), 32'd1);
        chk("stall wr", 32'(wq1.size() == 1 ? wq1[0] : 19'h7FFFF),
            32'({11'd0, 8'h55}));
        do_clear();

        // Full-depth image: LEN = 2048, every address once
        wq1.delete();
        send(1, 8'hA5); send(1, 8'h00); send(1, 8'h08);
        for (int k = 0; k < 2048; k++) send(1, 8'(k));
        send(1, 8'h00);
        @(negedge clk);
        chk("full done", 32'(dn1), 32'd1);
        chk("full cnt", 32'(bc1), 32'd2048);
        chk("full nwr", 32'(wq1.size()), 32'd2048);
        begin
            int bad = 0;
            for (int k = 0; k < 2048 && k < wq1.size(); k++)
                if (wq1[k] !== {11'(k), 8'(k)}) bad++;
            chk("full wr", 32'(bad), 32'd0);
        end
        do_clear();

        // Asynchronous reset mid-frame
        wq1.delete();
        send(1, 8'hA5); send(1, 8'h05); send(1, 8'h00);
        send(1, 8'h01); send(1, 8'h02);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst we", 32'(we1), 32'd0);
        chk("arst addr", 32'(a1), 32'd0);
        chk("arst wdata", 32'(wd1), 32'd0);
        chk("arst ready", 32'(rdy1), 32'd0);
        chk("arst hold", 32'(h1), 32'd1);
        chk("arst cnt", 32'(bc1), 32'd0);
        chk("arst done", 32'(dn1), 32'd0);
        chk("arst err", 32'(er1), 32'd0);
        chk("arst code", 32'(ec1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wq1.delete();
        repeat (3) @(negedge clk);
        chk("arst nowr", 32'(wq1.size()), 32'd0);
        send(1, 8'hA5); send(1, 8'h01); send(1, 8'h00);
        send(1, 8'h77); send(1, 8'h77);
        @(negedge clk);
        chk("arst reload done", 32'(dn1), 32'd1);
        chk("arst reload hold", 32'(h1), 32'd0);
        chk("arst reload wr", 32'(wq1.size() == 1 ? wq1[0] : 19'h7FFFF),
            32'({11'd0, 8'h77}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
